// File: rtl/approx_pkg.sv
// ============================================================================
// Module      : approx_pkg
// Description : Shared widths, output-slot state encoding and arithmetic
//               helpers for the approximate-adder arbiter family.
//               OPW  - operand width (signed two's complement)
//               SUMW - sum width (signed, one guard bit)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package approx_pkg;

   localparam int OPW  = 8;
   localparam int SUMW = 9;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   // Sign-extend an 8-bit operand to the 9-bit sum width.
   function automatic logic [SUMW-1:0] sext9(input logic [OPW-1:0] x);
      return {x[OPW-1], x};
   endfunction

   // |approx - exact| computed in 10 bits so no difference overflows,
   // then clamped to the largest value a 9-bit unsigned field can hold.
   function automatic logic [SUMW-1:0] abs_diff9(input logic [SUMW-1:0] approx,
                                                 input logic [SUMW-1:0] exact);
      logic [SUMW:0] d;
      logic [SUMW:0] m;
      d = {approx[SUMW-1], approx} - {exact[SUMW-1], exact};
      m = d[SUMW] ? ((SUMW+1)'(0) - d) : d;
      return (m > (SUMW+1)'(511)) ? SUMW'(511) : m[SUMW-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant over NUM_REQ requesters. The search starts
//               at the stored pointer; on a granted cycle the pointer moves to
//               one past the winner (wrapping), otherwise it holds.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               i_req        - request vector
//               i_en         - grant permitted this cycle
//               o_gnt        - one-hot grant (zero when !i_en or no request)
//               o_gnt_id     - index of the winner (valid when o_gnt_vld)
//               o_gnt_vld    - a grant is issued this cycle
//               o_ptr        - current round-robin start pointer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_gnt_id,
   output logic               o_gnt_vld,
   output logic [ID_W-1:0]    o_ptr
);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_gid;
   logic            w_found;
   logic [ID_W:0]   w_idx;

   // Walk the requesters starting at r_ptr; the first active one wins.
   always_comb begin
      w_found = 1'b0;
      w_gid   = r_ptr;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
            w_idx = w_idx - (ID_W+1)'(NUM_REQ);
         end
         if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_gid   = w_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      o_gnt = '0;
      if (i_en && w_found) begin
         o_gnt[w_gid] = 1'b1;
      end
   end

   assign o_gnt_id  = w_gid;
   assign o_gnt_vld = i_en && w_found;
   assign o_ptr     = r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_en && w_found) begin
         if (w_gid == ID_W'(NUM_REQ-1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_gid + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/approx_add_arbiter.sv
// ============================================================================
// Module      : approx_add_arbiter
// Description : Shares one external combinational 8-bit signed approximate
//               adder among NUM_REQ requesters (round-robin, valid/ready).
//               Each accepted operation is registered with its requester ID,
//               the approximate-vs-exact error, and running error statistics.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               req_valid/a/b         - per-requester request and operands
//               req_ready             - one-hot accept (or zero)
//               add_a/add_b, add_o    - external adder operands / sum
//               cfg_exact             - return exact sum instead of add_o
//               rsp_valid/ready       - result handshake
//               rsp_id/sum/err        - result ID, sum, |add_o - exact|
//               stat_clr              - clear statistics
//               stat_ops/err_sum/max  - op count, saturating error sum, max
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_add_arbiter
   import approx_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*OPW-1:0] req_a,
   input  logic [NUM_REQ*OPW-1:0] req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [OPW-1:0]         add_a,
   output logic [OPW-1:0]         add_b,
   input  logic [SUMW-1:0]        add_o,
   input  logic                   cfg_exact,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [SUMW-1:0]        rsp_sum,
   output logic [SUMW-1:0]        rsp_err,
   input  logic                   stat_clr,
   output logic [CNT_W-1:0]       stat_ops,
   output logic [CNT_W-1:0]       stat_err_sum,
   output logic [SUMW-1:0]        stat_err_max
);

   slot_state_e     r_state;
   logic [ID_W-1:0] r_rsp_id;
   logic [SUMW-1:0] r_rsp_sum;
   logic [SUMW-1:0] r_rsp_err;
   logic [CNT_W-1:0] r_ops;
   logic [CNT_W-1:0] r_err_sum;
   logic [SUMW-1:0]  r_err_max;

   logic            w_can_accept;
   logic            w_accept;
   logic [ID_W-1:0] w_gid;
   logic [ID_W-1:0] w_ptr;
   logic [ID_W-1:0] w_sel;
   logic [SUMW-1:0] w_exact;
   logic [SUMW-1:0] w_err;
   logic [CNT_W-1:0] w_ops_base;
   logic [CNT_W-1:0] w_sum_base;
   logic [SUMW-1:0]  w_max_base;
   logic [CNT_W:0]   w_sum_ext;

   // A full slot may still accept when it is being drained this cycle.
   assign w_can_accept = (r_state == EMPTY) || rsp_ready;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req_valid),
      .i_en      (w_can_accept),
      .o_gnt     (req_ready),
      .o_gnt_id  (w_gid),
      .o_gnt_vld (w_accept),
      .o_ptr     (w_ptr)
   );

   // Idle cycles present the pointed-to requester so the adder inputs
   // only move when the pointer does.
   assign w_sel = w_accept ? w_gid : w_ptr;
   assign add_a = req_a[int'(w_sel)*OPW +: OPW];
   assign add_b = req_b[int'(w_sel)*OPW +: OPW];

   assign w_exact = sext9(add_a) + sext9(add_b);
   assign w_err   = abs_diff9(add_o, w_exact);

   // A clear in the same cycle as an accept starts the statistics from zero.
   assign w_ops_base = stat_clr ? '0 : r_ops;
   assign w_sum_base = stat_clr ? '0 : r_err_sum;
   assign w_max_base = stat_clr ? '0 : r_err_max;
   assign w_sum_ext  = {1'b0, w_sum_base} + {{(CNT_W-SUMW+1){1'b0}}, w_err};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= EMPTY;
         r_rsp_id  <= '0;
         r_rsp_sum <= '0;
         r_rsp_err <= '0;
         r_ops     <= '0;
         r_err_sum <= '0;
         r_err_max <= '0;
      end else begin
         if (w_accept) begin
            r_state   <= FULL;
            r_rsp_id  <= w_gid;
            r_rsp_sum <= cfg_exact ? w_exact : add_o;
            r_rsp_err <= w_err;
            r_ops     <= w_ops_base + 1'b1;
            r_err_sum <= w_sum_ext[CNT_W] ? '1 : w_sum_ext[CNT_W-1:0];
            r_err_max <= (w_err > w_max_base) ? w_err : w_max_base;
         end else begin
            if (r_state == FULL && rsp_ready) begin
               r_state <= EMPTY;
            end
            if (stat_clr) begin
               r_ops     <= '0;
               r_err_sum <= '0;
               r_err_max <= '0;
            end
         end
      end
   end

   assign rsp_valid    = (r_state == FULL);
   assign rsp_id       = r_rsp_id;
   assign rsp_sum      = r_rsp_sum;
   assign rsp_err      = r_rsp_err;
   assign stat_ops     = r_ops;
   assign stat_err_sum = r_err_sum;
   assign stat_err_max = r_err_max;

endmodule

`default_nettype wire

// File: tb/tb_approx_add_arbiter.sv
// ============================================================================
// Module      : tb_approx_add_arbiter
// Description : Directed self-checking bench for approx_add_arbiter. A narrow
//               counter width lets the error-sum saturation be reached with a
//               handful of operations. The bench plays the external adder by
//               driving add_o directly with chosen values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_approx_add_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int CNT_W   = 10;

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_a;
   logic [NUM_REQ*8-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           add_a;
   logic [7:0]           add_b;
   logic [8:0]           add_o;
   logic                 cfg_exact;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [8:0]           rsp_sum;
   logic [8:0]           rsp_err;
   logic                 stat_clr;
   logic [CNT_W-1:0]     stat_ops;
   logic [CNT_W-1:0]     stat_err_sum;
   logic [8:0]           stat_err_max;

   int checks = 0;
   int errors = 0;

   approx_add_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_ready    (req_ready),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_o        (add_o),
      .cfg_exact    (cfg_exact),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_sum      (rsp_sum),
      .rsp_err      (rsp_err),
      .stat_clr     (stat_clr),
      .stat_ops     (stat_ops),
      .stat_err_sum (stat_err_sum),
      .stat_err_max (stat_err_max)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      add_o     = '0;
      cfg_exact = 1'b0;
      rsp_ready = 1'b0;
      stat_clr  = 1'b0;
      #1;
      chk("rst_valid",   32'(rsp_valid),    32'h0);
      chk("rst_id",      32'(rsp_id),       32'h0);
      chk("rst_sum",     32'(rsp_sum),      32'h0);
      chk("rst_err",     32'(rsp_err),      32'h0);
      chk("rst_ops",     32'(stat_ops),     32'h0);
      chk("rst_err_sum", 32'(stat_err_sum), 32'h0);
      chk("rst_err_max", 32'(stat_err_max), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // Single request: 3 + 4 = 7, adder reports 8 -> error 1.
      req_valid = 4'b0001;
      req_a     = {8'd0, 8'd0, 8'd0, 8'd3};
      req_b     = {8'd0, 8'd0, 8'd0, 8'd4};
      add_o     = 9'h008;
      #1;
      chk("t1_ready", 32'(req_ready), 32'h1);
      chk("t1_add_a", 32'(add_a),     32'h3);
      chk("t1_add_b", 32'(add_b),     32'h4);
      tick();
      req_valid = '0;
      chk("t1_valid",   32'(rsp_valid),    32'h1);
      chk("t1_id",      32'(rsp_id),       32'h0);
      chk("t1_sum",     32'(rsp_sum),      32'h008);
      chk("t1_err",     32'(rsp_err),      32'h1);
      chk("t1_ops",     32'(stat_ops),     32'h1);
      chk("t1_err_sum", 32'(stat_err_sum), 32'h1);
      chk("t1_err_max", 32'(stat_err_max), 32'h1);
      rsp_ready = 1'b1;
      tick();
      chk("t1_drained", 32'(rsp_valid), 32'h0);

      // Exact mode: -128 + -128 = -256, adder reports 0 -> error 256.
      req_valid = 4'b0001;
      req_a     = {8'd0, 8'd0, 8'd0, 8'h80};
      req_b     = {8'd0, 8'd0, 8'd0, 8'h80};
      add_o     = 9'h000;
      cfg_exact = 1'b1;
      #1;
      chk("t2_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      rsp_ready = 1'b0;
      chk("t2_sum",     32'(rsp_sum),      32'h100);
      chk("t2_err",     32'(rsp_err),      32'd256);
      chk("t2_ops",     32'(stat_ops),     32'd2);
      chk("t2_err_sum", 32'(stat_err_sum), 32'd257);
      chk("t2_err_max", 32'(stat_err_max), 32'd256);

      // Asynchronous reset while the slot is full.
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid",   32'(rsp_valid),    32'h0);
      chk("ar_ops",     32'(stat_ops),     32'h0);
      chk("ar_err_sum", 32'(stat_err_sum), 32'h0);
      chk("ar_err_max", 32'(stat_err_max), 32'h0);
      tick();
      rst_n = 1'b1;

      // Fairness: all requesters valid, continuous drain.
      // Operands a_i = i+1, b_i = 2, adder reports 0 -> sum/err = i+3.
      req_valid = 4'b1111;
      req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
      req_b     = {8'd2, 8'd2, 8'd2, 8'd2};
      add_o     = 9'h000;
      cfg_exact = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("fair_ready", 32'(req_ready), 32'(1 << (i % 4)));
         tick();
         chk("fair_valid", 32'(rsp_valid), 32'h1);
         chk("fair_id",    32'(rsp_id),    32'(i % 4));
         chk("fair_sum",   32'(rsp_sum),   32'((i % 4) + 3));
      end
      chk("fair_ops",     32'(stat_ops),     32'd5);
      chk("fair_err_sum", 32'(stat_err_sum), 32'd21);
      chk("fair_err_max", 32'(stat_err_max), 32'd6);

      // Backpressure: held result (id 0, sum 3) must not move, even when
      // cfg_exact changes underneath it.
      rsp_ready = 1'b0;
      cfg_exact = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'h0);
         tick();
         chk("bp_valid", 32'(rsp_valid), 32'h1);
         chk("bp_id",    32'(rsp_id),    32'h0);
         chk("bp_sum",   32'(rsp_sum),   32'd3);
         chk("bp_ops",   32'(stat_ops),  32'd5);
      end
      cfg_exact = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      chk("bp_next_valid", 32'(rsp_valid), 32'h1);
      chk("bp_next_id",    32'(rsp_id),    32'h1);
      chk("bp_next_sum",   32'(rsp_sum),   32'd4);
      chk("bp_next_ops",   32'(stat_ops),  32'd6);
      tick();
      chk("bp_drained", 32'(rsp_valid), 32'h0);

      // Saturation: -128 + -128 = -256 vs adder 255 -> error 511.
      req_valid = 4'b0001;
      req_a     = {8'd0, 8'd0, 8'd0, 8'h80};
      req_b     = {8'd0, 8'd0, 8'd0, 8'h80};
      add_o     = 9'h0FF;
      stat_clr  = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("sat_err",      32'(rsp_err),      32'd511);
      chk("sat_ops1",     32'(stat_ops),     32'd1);
      chk("sat_err_sum1", 32'(stat_err_sum), 32'd511);
      tick();
      chk("sat_err_sum2", 32'(stat_err_sum), 32'd1022);
      // 0 + 0 vs adder 16 -> error 16, pushes the sum past all-ones.
      req_a = '0;
      req_b = '0;
      add_o = 9'd16;
      tick();
      chk("sat_err16",    32'(rsp_err),      32'd16);
      chk("sat_sum0",     32'(rsp_sum),      32'd0);
      chk("sat_ops3",     32'(stat_ops),     32'd3);
      chk("sat_err_sum3", 32'(stat_err_sum), 32'h3FF);
      chk("sat_err_max3", 32'(stat_err_max), 32'd511);
      // Clear together with an accept of error 5.
      add_o    = 9'd5;
      stat_clr = 1'b1;
      tick();
      stat_clr  = 1'b0;
      req_valid = '0;
      chk("clr_ops",     32'(stat_ops),     32'd1);
      chk("clr_err_sum", 32'(stat_err_sum), 32'd5);
      chk("clr_err_max", 32'(stat_err_max), 32'd5);
      tick();
      // Clear with no accept.
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr0_ops",     32'(stat_ops),     32'd0);
      chk("clr0_err_sum", 32'(stat_err_sum), 32'd0);
      chk("clr0_err_max", 32'(stat_err_max), 32'd0);
      chk("clr0_valid",   32'(rsp_valid),    32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
